// File: rtl/id_stage_pipelined.sv
// Instruction-decode stage with integrated ID/EX register: decode, bypassed register
// file, condition evaluation, RAW hazard stall and a saturating stall counter.
module id_stage_pipelined #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter bit          FWD_EN         = 1'b1,
  parameter int unsigned PERF_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_WIDTH-1:0]     pc_in,
  input  logic [WORD_WIDTH-1:0]     instr_in,
  input  logic [3:0]                status_reg,
  input  logic                      flush,
  input  logic                      freeze,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [WORD_WIDTH-1:0]     wb_data,
  input  logic                      ex_wb_en,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_dst,
  input  logic                      mem_wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] mem_dst,
  output logic                      out_valid,
  output logic [WORD_WIDTH-1:0]     out_pc,
  output logic [WORD_WIDTH-1:0]     out_instr,
  output logic [WORD_WIDTH-1:0]     out_val_rn,
  output logic [WORD_WIDTH-1:0]     out_val_rm,
  output logic [REG_ADDR_WIDTH-1:0] out_dst,
  output logic [REG_ADDR_WIDTH-1:0] out_src1,
  output logic [REG_ADDR_WIDTH-1:0] out_src2,
  output logic [3:0]                out_ex_cmd,
  output logic                      out_wb_en,
  output logic                      out_mem_read,
  output logic                      out_mem_write,
  output logic                      out_branch,
  output logic                      out_sr_update,
  output logic                      out_imm,
  output logic [11:0]               out_shift_op,
  output logic [23:0]               out_simm,
  output logic [PERF_WIDTH-1:0]     stall_count
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [3:0] cond;
  logic [1:0] mode;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;

  assign cond   = instr_in[31:28];
  assign mode   = instr_in[27:26];
  assign i_bit  = instr_in[25];
  assign opcode = instr_in[24:21];
  assign s_bit  = instr_in[20];

  // Raw control decode, before the condition check
  logic [3:0] d_ex_cmd;
  logic       d_wb_en, d_mem_read, d_mem_write, d_branch, d_sr_update;

  always_comb begin
    d_ex_cmd    = 4'b0000;
    d_wb_en     = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_branch    = 1'b0;
    d_sr_update = 1'b0;
    case (mode)
      2'b00: begin
        d_ex_cmd    = opcode;
        d_sr_update = s_bit;
        d_wb_en     = !(opcode == 4'b1000 || opcode == 4'b1010);
      end
      2'b01: begin
        d_ex_cmd = 4'b0010;
        if (s_bit) begin
          d_mem_read = 1'b1;
          d_wb_en    = 1'b1;
        end else begin
          d_mem_write = 1'b1;
        end
      end
      2'b10:   d_branch = 1'b1;
      default: ;
    endcase
  end

  // Condition evaluation against {N,Z,C,V}
  logic flag_n, flag_z, flag_c, flag_v, cond_pass;
  assign {flag_n, flag_z, flag_c, flag_v} = status_reg;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  logic [REG_ADDR_WIDTH-1:0] src1, src2, dst;
  logic                      has_src1, has_src2;

  assign src1     = REG_ADDR_WIDTH'(instr_in[19:16]);
  assign dst      = REG_ADDR_WIDTH'(instr_in[15:12]);
  assign src2     = d_mem_write ? dst : REG_ADDR_WIDTH'(instr_in[3:0]);
  assign has_src1 = !d_branch;
  assign has_src2 = (!i_bit || d_mem_write) && !d_branch;

  // Register file, write-first bypass on both read ports
  logic [WORD_WIDTH-1:0] regs [NUM_REGS];
  logic [WORD_WIDTH-1:0] val_rn, val_rm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign val_rn = (wb_en && wb_addr == src1) ? wb_data : regs[src1];
  assign val_rm = (wb_en && wb_addr == src2) ? wb_data : regs[src2];

  // RAW hazard against in-flight EX/MEM destinations
  logic ex_hit, mem_hit, hazard;

  assign ex_hit  = ex_wb_en && ((has_src1 && src1 == ex_dst) || (has_src2 && src2 == ex_dst));
  assign mem_hit = mem_wb_en && ((has_src1 && src1 == mem_dst) || (has_src2 && src2 == mem_dst));
  assign hazard  = in_valid && (FWD_EN ? (ex_hit && ex_mem_read) : (ex_hit || mem_hit));
  assign in_ready = !freeze && !hazard && !flush;

  logic issue;
  assign issue = in_valid && cond_pass;

  // ID/EX register: flush > freeze > hazard bubble > load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_instr     <= '0;
      out_val_rn    <= '0;
      out_val_rm    <= '0;
      out_dst       <= '0;
      out_src1      <= '0;
      out_src2      <= '0;
      out_ex_cmd    <= 4'b0000;
      out_wb_en     <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_branch    <= 1'b0;
      out_sr_update <= 1'b0;
      out_imm       <= 1'b0;
      out_shift_op  <= 12'h000;
      out_simm      <= 24'h000000;
      stall_count   <= '0;
    end else if (flush || (!freeze && hazard)) begin
      out_valid     <= 1'b0;
      out_ex_cmd    <= 4'b0000;
      out_wb_en     <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_branch    <= 1'b0;
      out_sr_update <= 1'b0;
      out_imm       <= 1'b0;
      if (!flush && stall_count != '1) stall_count <= stall_count + PERF_WIDTH'(1);
    end else if (!freeze) begin
      out_valid     <= in_valid;
      out_pc        <= pc_in;
      out_instr     <= instr_in;
      out_val_rn    <= val_rn;
      out_val_rm    <= val_rm;
      out_dst       <= dst;
      out_src1      <= src1;
      out_src2      <= src2;
      out_ex_cmd    <= issue ? d_ex_cmd : 4'b0000;
      out_wb_en     <= issue && d_wb_en;
      out_mem_read  <= issue && d_mem_read;
      out_mem_write <= issue && d_mem_write;
      out_branch    <= issue && d_branch;
      out_sr_update <= issue && d_sr_update;
      out_imm       <= in_valid && i_bit;
      out_shift_op  <= instr_in[11:0];
      out_simm      <= instr_in[23:0];
    end
  end

endmodule
